// File: rtl/sha_digest_serializer.sv
// Captures SHA-256 digests on hash_valid rising edges and streams each one as NUM_WORDS
// words, H0 first, through a two-slot buffer. Optional macro DIGEST_CHECK_EN adds a digest compare.
module sha_digest_serializer #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hash_valid,
    input  logic [NUM_WORDS*WORD_W-1:0] hash_data,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        overflow,
    input  logic                        overflow_clr,
`ifdef DIGEST_CHECK_EN
    input  logic [NUM_WORDS*WORD_W-1:0] expected_digest,
    output logic                        match_valid,
    output logic                        match,
`endif
    output logic [0:0]                  fsm_state
);

    localparam int DIGEST_W = NUM_WORDS * WORD_W;
    localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]          state;
    logic                hv_q;
    logic [DIGEST_W-1:0] active;
    logic [DIGEST_W-1:0] pending;
    logic                pend_full;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   word_sel;

    logic capture;
    logic hs;
    logic last_hs;
    logic overflow_set;

    // Handshake: a word transfers on a rising clk edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_last/idx do not change.
    assign capture      = hash_valid && !hv_q;
    assign hs           = out_valid && out_ready;
    assign last_hs      = hs && (idx == LAST_IDX);
    // A capture racing the final handshake always finds a slot, so it never overflows.
    assign overflow_set = capture && (state == S_SEND) && pend_full && !last_hs;

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                word_sel = active[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
            end
        end
    end

    assign out_valid = (state == S_SEND);
    assign busy      = (state == S_SEND);
    assign out_last  = (state == S_SEND) && (idx == LAST_IDX);
    assign out_data  = (state == S_SEND) ? word_sel : '0;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            hv_q      <= 1'b0;
            active    <= '0;
            pending   <= '0;
            pend_full <= 1'b0;
            idx       <= '0;
            overflow  <= 1'b0;
        end else begin
            hv_q <= hash_valid;

            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (capture) begin
                        active <= hash_data;
                        idx    <= '0;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (last_hs) begin
                        idx <= '0;
                        if (pend_full) begin
                            active <= pending;
                            if (capture) begin
                                pending <= hash_data;
                            end else begin
                                pend_full <= 1'b0;
                            end
                        end else if (capture) begin
                            active <= hash_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        if (hs) begin
                            idx <= idx + 1'b1;
                        end
                        if (capture && !pend_full) begin
                            pending   <= hash_data;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DIGEST_CHECK_EN
    // Every capture is compared, including ones dropped for lack of a free slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_valid <= 1'b0;
            match       <= 1'b0;
        end else begin
            match_valid <= capture;
            if (capture) begin
                match <= (hash_data == expected_digest);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha_digest_serializer.sv
// Directed bench for sha_digest_serializer: single digest, stalls, back-to-back digests,
// overflow, reset mid-digest and (with DIGEST_CHECK_EN) the digest compare.
module tb_sha_digest_serializer;

    localparam int W = 32;
    localparam int D = 256;

    localparam logic [D-1:0] ABC = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
    localparam logic [D-1:0] DA  = 256'hA0000001_A1111112_A2222223_A3333334_A4444445_A5555556_A6666667_A7777778;
    localparam logic [D-1:0] DB  = 256'hB0000001_B1111112_B2222223_B3333334_B4444445_B5555556_B6666667_B7777778;
    localparam logic [D-1:0] DC  = 256'hC0000001_C1111112_C2222223_C3333334_C4444445_C5555556_C6666667_C7777778;
    localparam logic [D-1:0] DD  = 256'hD0000001_D1111112_D2222223_D3333334_D4444445_D5555556_D6666667_D7777778;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         hash_valid = 1'b0;
    logic [D-1:0] hash_data = '0;
    logic         out_ready = 1'b0;
    logic         overflow_clr = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         busy;
    logic         overflow;
    logic [0:0]   fsm_state;
`ifdef DIGEST_CHECK_EN
    logic [D-1:0] expected_digest = '0;
    logic         match_valid;
    logic         match;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    sha_digest_serializer #(.NUM_WORDS(8), .WORD_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .hash_valid     (hash_valid),
        .hash_data      (hash_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr),
`ifdef DIGEST_CHECK_EN
        .expected_digest(expected_digest),
        .match_valid    (match_valid),
        .match          (match),
`endif
        .fsm_state      (fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver helper: expected words of a digest, H0 first
    task automatic push_digest(input logic [D-1:0] d);
        logic [D-1:0] t;
        t = d;
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back(t[D-1 -: W]);
            t = t << W;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hash_valid = 1'b0;
        out_ready = 1'b0;
        overflow_clr = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int got = 0;
        logic [W-1:0] exp_w;
        exp_q.delete();
        push_digest(ABC);
        hash_data = ABC;
        hash_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== (k < 8)) begin miscompares++; $display("FAIL single_valid k=%0d: got %b expected %b", k, out_valid, (k < 8)); end
            if (out_valid && out_ready) begin
                got++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL single_extra_word: got %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin miscompares++; $display("FAIL single_word k=%0d: got %h expected %h", k, out_data, exp_w); end
                    vectors++;
                    if (out_last !== (exp_q.size() % 8 == 0)) begin miscompares++; $display("FAIL single_last k=%0d: got %b expected %b", k, out_last, (exp_q.size() % 8 == 0)); end
                end
            end
            if (k == 2) hash_valid = 1'b0;
        end
        vectors++;
        if (got != 8) begin miscompares++; $display("FAIL single_count: got %0d expected 8", got); end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int got = 0;
        int k = 0;
        logic [3:0] pat = 4'b1001;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [W-1:0] exp_w;
        exp_q.delete();
        push_digest(ABC);
        hash_data = ABC;
        hash_valid = 1'b1;
        out_ready = 1'b0;
        while (got < 8 && k < 80) begin
            @(negedge clk);
            if (k == 0) hash_valid = 1'b0;
            if (prev_stall) begin
                vectors++;
                if (out_data !== prev_data || out_last !== prev_last || out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_hold k=%0d: got %h/%b expected %h/%b", k, out_data, out_last, prev_data, prev_last);
                end
            end
            out_ready = pat[k[1:0]];
            if (out_valid && out_ready) begin
                got++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL stall_extra_word: got %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w || out_last !== (exp_q.size() % 8 == 0)) begin
                        miscompares++;
                        $display("FAIL stall_word k=%0d: got %h/%b expected %h/%b", k, out_data, out_last, exp_w, (exp_q.size() % 8 == 0));
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            k++;
        end
        vectors++;
        if (got != 8) begin miscompares++; $display("FAIL stall_count: got %0d expected 8", got); end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_idle: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back(input int n, input int cap1, input int cap2);
        logic [D-1:0] dig [3];
        int got = 0;
        logic [W-1:0] exp_w;
        dig[0] = DA;
        dig[1] = DB;
        dig[2] = DC;
        exp_q.delete();
        for (int i = 0; i < n; i++) push_digest(dig[i]);
        hash_data = dig[0];
        hash_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8 * n + 2; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== (k < 8 * n)) begin miscompares++; $display("FAIL b2b_valid n=%0d k=%0d: got %b expected %b", n, k, out_valid, (k < 8 * n)); end
            if (out_valid && out_ready) begin
                got++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL b2b_extra_word: got %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w || out_last !== (exp_q.size() % 8 == 0)) begin
                        miscompares++;
                        $display("FAIL b2b_word n=%0d k=%0d: got %h/%b expected %h/%b", n, k, out_data, out_last, exp_w, (exp_q.size() % 8 == 0));
                    end
                end
            end
            if (k == cap1 && n > 1) begin
                hash_data = dig[1];
                hash_valid = 1'b1;
            end else if (k == cap2 && n > 2) begin
                hash_data = dig[2];
                hash_valid = 1'b1;
            end else begin
                hash_valid = 1'b0;
            end
        end
        vectors++;
        if (got != 8 * n) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", got, 8 * n); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int got = 0;
        logic [W-1:0] exp_w;
        exp_q.delete();
        push_digest(DA);
        push_digest(DB);
        hash_data = DA;
        hash_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k)
                0: hash_valid = 1'b0;
                1: begin hash_data = DB; hash_valid = 1'b1; end
                2: hash_valid = 1'b0;
                3: begin
                    vectors++;
                    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b expected 0", overflow); end
                    hash_data = DC;
                    hash_valid = 1'b1;
                end
                4: begin
                    vectors++;
                    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", overflow); end
                    vectors++;
                    if (out_data !== DA[D-1 -: W] || busy !== 1'b1) begin
                        miscompares++; $display("FAIL ovf_stalled_word: got %h/%b expected %h/1", out_data, busy, DA[D-1 -: W]);
                    end
                    hash_valid = 1'b0;
                end
                5: begin hash_data = DD; hash_valid = 1'b1; overflow_clr = 1'b1; end
                6: begin
                    vectors++;
                    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
                    hash_valid = 1'b0;
                end
                default: begin
                    vectors++;
                    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
                    overflow_clr = 1'b0;
                end
            endcase
        end
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (out_valid !== (k < 16)) begin miscompares++; $display("FAIL ovf_drain_valid k=%0d: got %b expected %b", k, out_valid, (k < 16)); end
            if (out_valid && out_ready) begin
                got++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL ovf_extra_word: got %h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w || out_last !== (exp_q.size() % 8 == 0)) begin
                        miscompares++;
                        $display("FAIL ovf_word k=%0d: got %h/%b expected %h/%b", k, out_data, out_last, exp_w, (exp_q.size() % 8 == 0));
                    end
                end
            end
        end
        vectors++;
        if (got != 16) begin miscompares++; $display("FAIL ovf_count: got %0d expected 16", got); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_stays_clear: got %b expected 0", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int waited = 0;
        hash_data = DA;
        hash_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) begin hash_data = DB; hash_valid = 1'b1; end
            else hash_valid = 1'b0;
        end
        vectors++;
        if (out_data !== DA[D-1-4*W -: W]) begin miscompares++; $display("FAIL rstmid_word4: got %h expected %h", out_data, DA[D-1-4*W -: W]); end
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL rstmid_no_residue: got %0d valid cycles expected 0", seen); end
        hash_data = DC;
        hash_valid = 1'b1;
        @(negedge clk);
        hash_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== DC[D-1 -: W]) begin
            miscompares++; $display("FAIL rstmid_restart: got %b/%h expected 1/%h", out_valid, out_data, DC[D-1 -: W]);
        end
        while (out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_drain: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

`ifdef DIGEST_CHECK_EN
    task automatic test_digest_check();
        logic [D-1:0] flip;
        flip = '0;
        flip[77] = 1'b1;
        out_ready = 1'b1;
        expected_digest = ABC;
        hash_data = ABC;
        hash_valid = 1'b1;
        @(negedge clk);
        hash_valid = 1'b0;
        vectors++;
        if (match_valid !== 1'b1 || match !== 1'b1) begin miscompares++; $display("FAIL chk_match: got %b/%b expected 1/1", match_valid, match); end
        @(negedge clk);
        vectors++;
        if (match_valid !== 1'b0 || match !== 1'b1) begin miscompares++; $display("FAIL chk_hold: got %b/%b expected 0/1", match_valid, match); end
        repeat (10) @(negedge clk);
        expected_digest = ABC ^ flip;
        hash_valid = 1'b1;
        @(negedge clk);
        hash_valid = 1'b0;
        vectors++;
        if (match_valid !== 1'b1 || match !== 1'b0) begin miscompares++; $display("FAIL chk_mismatch: got %b/%b expected 1/0", match_valid, match); end
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back(2, 2, 0);
        test_back_to_back(2, 7, 0);
        test_back_to_back(3, 2, 7);
        test_overflow();
        test_reset_mid();
`ifdef DIGEST_CHECK_EN
        test_digest_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
